// File: rtl/bram_pkg.sv
// Shared types and the byte-lane merge helper for the true dual-port RAM family.
// Widths up to LM_W bits / LM_COL lanes; callers size-cast to their own word width.
package bram_pkg;

    localparam int LM_W   = 256;
    localparam int LM_COL = 32;

    typedef enum logic [1:0] {
        READ_FIRST  = 2'd0,
        WRITE_FIRST = 2'd1,
        NO_CHANGE   = 2'd2
    } rdw_mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clear_st_e;

    // Lane i of the result is new_w where be[i] is set, old_w otherwise.
    function automatic logic [LM_W-1:0] lane_merge(
        input logic [LM_W-1:0]   old_w,
        input logic [LM_W-1:0]   new_w,
        input logic [LM_COL-1:0] be,
        input int                col_width
    );
        logic [LM_W-1:0] res;
        res = old_w;
        for (int i = 0; i < LM_W; i++) begin
            if (col_width > 0 && (i / col_width) < LM_COL && be[i / col_width]) begin
                res[i] = new_w[i];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/bram_rd_pipe.sv
// Read pipeline: READ_LATENCY register stages, stage 1 captures the array word.
// No backpressure; each stage only loads when its input is valid so dout holds between reads.
module bram_rd_pipe #(
    parameter int READ_LATENCY = 2,
    parameter int DATA_WIDTH   = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [DATA_WIDTH-1:0] rd_dat,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid
);

    logic [READ_LATENCY-1:0] vld_sr;
    logic [DATA_WIDTH-1:0]   dat_sr [READ_LATENCY];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                dat_sr[i] <= '0;
            end
        end else begin
            vld_sr[0] <= req;
            if (req) begin
                dat_sr[0] <= rd_dat;
            end
            for (int i = 1; i < READ_LATENCY; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                if (vld_sr[i-1]) begin
                    dat_sr[i] <= dat_sr[i-1];
                end
            end
        end
    end

    assign dout  = dat_sr[READ_LATENCY-1];
    assign valid = vld_sr[READ_LATENCY-1];

endmodule

// File: rtl/bram_tdp_be_ctrl.sv
// True dual-port byte-enable RAM with clear engine; reads valid READ_LATENCY cycles after request.
// No backpressure: one access per port per cycle, ports masked while the clear sweep runs.
module bram_tdp_be_ctrl
    import bram_pkg::*;
#(
    parameter int    NB_COL         = 4,
    parameter int    COL_WIDTH      = 8,
    parameter int    RAM_DEPTH      = 512,
    parameter int    ADDR_WIDTH     = $clog2(RAM_DEPTH),
    parameter int    READ_LATENCY   = 2,
    parameter string RDW_MODE       = "READ_FIRST",
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear_req,
    output logic                          busy,
    input  logic                          ena,
    input  logic [NB_COL-1:0]             wea,
    input  logic [ADDR_WIDTH-1:0]         addra,
    input  logic [NB_COL*COL_WIDTH-1:0]   dina,
    output logic [NB_COL*COL_WIDTH-1:0]   douta,
    output logic                          douta_valid,
    input  logic                          enb,
    input  logic [NB_COL-1:0]             web,
    input  logic [ADDR_WIDTH-1:0]         addrb,
    input  logic [NB_COL*COL_WIDTH-1:0]   dinb,
    output logic [NB_COL*COL_WIDTH-1:0]   doutb,
    output logic                          doutb_valid,
    output logic                          coll
);

    localparam int W = NB_COL * COL_WIDTH;
    localparam rdw_mode_e RDW = (RDW_MODE == "WRITE_FIRST") ? WRITE_FIRST :
                                (RDW_MODE == "NO_CHANGE")   ? NO_CHANGE   : READ_FIRST;
    localparam clear_st_e RST_ST = CLEAR_ON_RESET ? CLEAR : IDLE;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    function automatic logic [W-1:0] merge(
        input logic [W-1:0]      old_w,
        input logic [W-1:0]      new_w,
        input logic [NB_COL-1:0] be
    );
        return W'(lane_merge(LM_W'(old_w), LM_W'(new_w), LM_COL'(be), COL_WIDTH));
    endfunction

    logic [W-1:0] mem [RAM_DEPTH];

    clear_st_e             state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RST_ST;
            clr_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d    = CLEAR;
                    clr_addr_d = '0;
                end
            end
            CLEAR: begin
                clr_addr_d = clr_addr_q + 1'b1;
                if (clr_addr_q == LAST_ADDR) begin
                    state_d    = IDLE;
                    clr_addr_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q == CLEAR);

    logic         en_a, en_b, wr_a, wr_b, same_wr, rd_req_a, rd_req_b;
    logic [W-1:0] merge_a, merge_b, merge_ab, rd_dat_a, rd_dat_b;

    always_comb begin
        en_a     = ena & ~busy;
        en_b     = enb & ~busy;
        wr_a     = en_a & (|wea);
        wr_b     = en_b & (|web);
        same_wr  = wr_a & wr_b & (addra == addrb);
        merge_a  = merge(mem[addra], dina, wea);
        merge_b  = merge(mem[addrb], dinb, web);
        // Port A applied last so it owns lanes both ports enable.
        merge_ab = merge(merge_b, dina, wea);
        rd_req_a = en_a & (~(|wea) | (RDW != NO_CHANGE));
        rd_req_b = en_b & (~(|web) | (RDW != NO_CHANGE));
        rd_dat_a = (RDW == WRITE_FIRST && wr_a) ? merge_a : mem[addra];
        rd_dat_b = (RDW == WRITE_FIRST && wr_b) ? merge_b : mem[addrb];
    end

    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_addr_q] <= '0;
        end else if (same_wr) begin
            mem[addra] <= merge_ab;
        end else begin
            if (wr_a) begin
                mem[addra] <= merge_a;
            end
            if (wr_b) begin
                mem[addrb] <= merge_b;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coll <= 1'b0;
        end else begin
            coll <= same_wr & (|(wea & web));
        end
    end

    bram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (W)
    ) u_pipe_a (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req_a),
        .rd_dat (rd_dat_a),
        .dout   (douta),
        .valid  (douta_valid)
    );

    bram_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_WIDTH   (W)
    ) u_pipe_b (
        .clk    (clk),
        .rst    (rst),
        .req    (rd_req_b),
        .rd_dat (rd_dat_b),
        .dout   (doutb),
        .valid  (doutb_valid)
    );

endmodule

// File: tb/tb_bram_tdp_be_ctrl.sv
// Three instances (READ_FIRST/L3, WRITE_FIRST/L1, NO_CHANGE/L2) share one stimulus stream;
// expected reads are queued per instance/port and popped by a free-running monitor.
module tb_bram_tdp_be_ctrl;

    logic        clk, rst, clear_req, ena, enb;
    logic [3:0]  wea, web;
    logic [8:0]  addra, addrb;
    logic [31:0] dina, dinb;

    logic [31:0] dout [6];
    logic        vld  [6];
    logic        busy_v [3];
    logic        coll_v [3];

    typedef struct {
        logic [31:0] dat;
        int          cyc;
    } exp_t;

    exp_t        exp_q [6][$];
    logic [31:0] last  [6];
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic        coll_exp = 1'b0;
    logic        masked   = 1'b0;

    bram_tdp_be_ctrl #(.READ_LATENCY(3), .RDW_MODE("READ_FIRST")) u_rf (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_v[0]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[0]), .douta_valid(vld[0]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[1]), .doutb_valid(vld[1]),
        .coll(coll_v[0]));

    bram_tdp_be_ctrl #(.READ_LATENCY(1), .RDW_MODE("WRITE_FIRST")) u_wf (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_v[1]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[2]), .douta_valid(vld[2]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[3]), .doutb_valid(vld[3]),
        .coll(coll_v[1]));

    bram_tdp_be_ctrl #(.READ_LATENCY(2), .RDW_MODE("NO_CHANGE")) u_nc (
        .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy_v[2]),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(dout[4]), .douta_valid(vld[4]),
        .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(dout[5]), .doutb_valid(vld[5]),
        .coll(coll_v[2]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        case (d)
            0:       return 3;
            1:       return 1;
            default: return 2;
        endcase
    endfunction

    // Monitor: every valid pops one expectation (data + latency); idle outputs must hold.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            for (int c = 0; c < 6; c++) last[c] = '0;
        end else begin
            for (int c = 0; c < 6; c++) begin
                checks++;
                if (vld[c]) begin
                    if (exp_q[c].size() == 0) begin
                        errors++;
                        $display("FAIL unexpected_valid ch%0d: got valid dout=%h, required no valid", c, dout[c]);
                    end else begin
                        e = exp_q[c].pop_front();
                        if (dout[c] !== e.dat || (cyc - e.cyc) != lat(c / 2)) begin
                            errors++;
                            $display("FAIL read ch%0d: got %h after %0d cycles, required %h after %0d cycles",
                                     c, dout[c], cyc - e.cyc, e.dat, lat(c / 2));
                        end
                    end
                    last[c] = dout[c];
                end else if (dout[c] !== last[c]) begin
                    errors++;
                    $display("FAIL dout_hold ch%0d: got %h, required %h", c, dout[c], last[c]);
                end
            end
            for (int d = 0; d < 3; d++) begin
                checks++;
                if (coll_v[d] !== coll_exp) begin
                    errors++;
                    $display("FAIL coll dut%0d: got %b, required %b", d, coll_v[d], coll_exp);
                end
            end
        end
    end

    task automatic push(input int ch, input logic [31:0] v);
        exp_t e;
        e.dat = v;
        e.cyc = cyc;
        exp_q[ch].push_back(e);
    endtask

    // A read returns old to every mode; a write-with-read returns old (READ_FIRST),
    // new (WRITE_FIRST) and nothing (NO_CHANGE).
    task automatic expect_port(input int p, input logic en, input logic [3:0] we,
                               input logic [31:0] old_w, input logic [31:0] new_w);
        if (en) begin
            if (we == 4'b0000) begin
                for (int d = 0; d < 3; d++) push(d * 2 + p, old_w);
            end else begin
                push(p, old_w);
                push(2 + p, new_w);
            end
        end
    endtask

    task automatic op(input logic a_en, input logic [3:0] a_we, input logic [8:0] a_ad,
                      input logic [31:0] a_di, input logic [31:0] a_old, input logic [31:0] a_new,
                      input logic b_en, input logic [3:0] b_we, input logic [8:0] b_ad,
                      input logic [31:0] b_di, input logic [31:0] b_old, input logic [31:0] b_new,
                      input logic c_exp);
        ena = a_en; wea = a_we; addra = a_ad; dina = a_di;
        enb = b_en; web = b_we; addrb = b_ad; dinb = b_di;
        if (!masked) begin
            expect_port(0, a_en, a_we, a_old, a_new);
            expect_port(1, b_en, b_we, b_old, b_new);
        end
        @(posedge clk);
        coll_exp = c_exp;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) op(0, 4'h0, 9'd0, 0, 0, 0, 0, 4'h0, 9'd0, 0, 0, 0, 0);
    endtask

    task automatic check_busy_len(input string name);
        int n;
        n = 0;
        while (busy_v[0] && n < 2000) begin
            op(1, 4'hF, 9'd5, 32'hDEADBEEF, 0, 0, 1, 4'hF, 9'd5, 32'hCAFEF00D, 0, 0, 0);
            n++;
        end
        checks++;
        if (n != 512 || busy_v[1] !== 1'b0 || busy_v[2] !== 1'b0) begin
            errors++;
            $display("FAIL %s: busy high %0d cycles (others %b%b), required 512 (00)",
                     name, n, busy_v[1], busy_v[2]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (dout[c] !== 32'h0 || vld[c] !== 1'b0) begin
                errors++;
                $display("FAIL %s ch%0d: got dout=%h valid=%b, required 0/0", name, c, dout[c], vld[c]);
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (coll_v[d] !== 1'b0 || busy_v[d] !== 1'b1) begin
                errors++;
                $display("FAIL %s dut%0d: got coll=%b busy=%b, required 0/1", name, d, coll_v[d], busy_v[d]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear_req = 1'b0;
        ena = 0; enb = 0; wea = 0; web = 0; addra = 0; addrb = 0; dina = 0; dinb = 0;
        @(negedge clk); @(negedge clk);
        check_reset_outputs("reset_state");
        rst = 1'b0;

        // Reset clear sweep, masked requests during it, then reads of zeroed memory.
        masked = 1'b1;
        check_busy_len("reset_sweep_len");
        masked = 1'b0;
        op(1, 4'h0, 9'd0,   0, 0, 0, 1, 4'h0, 9'd511, 0, 0, 0, 0);
        op(1, 4'h0, 9'd5,   0, 0, 0, 1, 4'h0, 9'd256, 0, 0, 0, 0);

        // Byte-enable writes on both ports, then read back.
        op(1, 4'hF, 9'd5, 32'hAABBCCDD, 32'h0, 32'hAABBCCDD, 0, 4'h0, 9'd0, 0, 0, 0, 0);
        op(0, 4'h0, 9'd0, 0, 0, 0, 1, 4'b0101, 9'd5, 32'h11223344, 32'hAABBCCDD, 32'hAA22CC44, 0);
        op(1, 4'h0, 9'd5, 0, 32'hAA22CC44, 0, 0, 4'h0, 9'd0, 0, 0, 0, 0);
        idle(3);

        // Same-port read-during-write.
        op(1, 4'b0011, 9'd7, 32'hFFFFFFFF, 32'h0, 32'h0000FFFF, 0, 4'h0, 9'd0, 0, 0, 0, 0);
        idle(3);
        op(1, 4'h0, 9'd7, 0, 32'h0000FFFF, 0, 0, 4'h0, 9'd0, 0, 0, 0, 0);

        // Overlapping dual write: A owns the shared lane, coll pulses once.
        op(1, 4'b1100, 9'd9, 32'h11111111, 32'h0, 32'h11110000,
           1, 4'b0110, 9'd9, 32'h22222222, 32'h0, 32'h00222200, 1);
        op(1, 4'h0, 9'd9, 0, 32'h11112200, 0, 1, 4'h0, 9'd9, 0, 32'h11112200, 0, 0);
        // Disjoint masks: no collision.
        op(1, 4'b1100, 9'd9, 32'h11111111, 32'h11112200, 32'h11112200,
           1, 4'b0011, 9'd9, 32'h22222222, 32'h11112200, 32'h11112222, 0);
        op(1, 4'h0, 9'd9, 0, 32'h11112222, 0, 0, 4'h0, 9'd0, 0, 0, 0, 0);

        // Cross-port same-address: reader sees the pre-write word, then the new one.
        op(1, 4'hF, 9'd3, 32'h12345678, 32'h0, 32'h12345678, 1, 4'h0, 9'd3, 0, 32'h0, 0, 0);
        op(0, 4'h0, 9'd0, 0, 0, 0, 1, 4'h0, 9'd3, 0, 32'h12345678, 0, 0);
        idle(4);

        // Read in flight when the clear starts still returns pre-clear data.
        clear_req = 1'b1;
        op(1, 4'h0, 9'd3, 0, 32'h12345678, 0, 0, 4'h0, 9'd0, 0, 0, 0, 0);
        clear_req = 1'b0;
        masked = 1'b1;
        for (int i = 0; i < 99; i++) begin
            op(1, 4'hF, 9'd20, 32'hDEADBEEF, 0, 0, 1, 4'hF, 9'd20, 32'h5A5A5A5A, 0, 0, 0);
        end

        // Reset mid-sweep: outputs cleared, sweep restarts from address 0.
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_sweep_reset");
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        check_busy_len("restart_sweep_len");
        masked = 1'b0;

        op(1, 4'h0, 9'd5, 0, 32'h0, 0, 1, 4'h0, 9'd20, 0, 32'h0, 0, 0);
        op(1, 4'h0, 9'd3, 0, 32'h0, 0, 1, 4'h0, 9'd9,  0, 32'h0, 0, 0);
        idle(6);

        for (int c = 0; c < 6; c++) begin
            checks++;
            if (exp_q[c].size() != 0) begin
                errors++;
                $display("FAIL missing_reads ch%0d: got %0d outstanding, required 0", c, exp_q[c].size());
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
